// File: rtl/fifo_ram_ctrl.sv
// Single-clock FIFO controller around an external simple dual-port RAM.
// Tracks occupancy, hides RAM read latency and presents a 4-entry output buffer.
module fifo_ram_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter string       OUTPUT_REG = "TRUE"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int unsigned Lat = (OUTPUT_REG == "TRUE") ? 2 : 1;
    localparam logic [ADDR_WIDTH:0]   Full   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PtrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [Lat-1:0]        vpipe_q, vpipe_d;
    logic [DATA_WIDTH-1:0] buf_q [4];
    logic [1:0]            head_q, head_d, tail_q, tail_d;
    logic [2:0]            buf_cnt_q, buf_cnt_d;
    logic [1:0]            inflight, inflight_next;
    logic                  push, pop;

    function automatic logic [1:0] popcnt(input logic [Lat-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int unsigned i = 0; i < Lat; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        inflight  = popcnt(vpipe_q);
        in_ready  = (ram_cnt_q != Full);
        ram_we    = in_valid & in_ready & ~flush;
        // Credit check uses the registered buffer count; a same-cycle pop is not credited.
        ram_re    = ~flush & (ram_cnt_q != '0)
                    & (({1'b0, buf_cnt_q} + {2'b0, inflight}) < 4'd4);
        push      = vpipe_q[Lat-1];
        out_valid = (buf_cnt_q != 3'd0);
        pop       = out_valid & out_ready;
        ram_waddr = wptr_q;
        ram_wdata = in_data;
        ram_raddr = rptr_q;
        out_data  = buf_q[head_q];
        level     = level_q;
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        buf_cnt_d = buf_cnt_q;
        vpipe_d   = vpipe_q << 1;
        vpipe_d[0] = ram_re;

        if (ram_we) wptr_d = wptr_q + PtrOne;
        if (ram_re) rptr_d = rptr_q + PtrOne;

        unique case ({ram_we, ram_re})
            2'b10:   ram_cnt_d = ram_cnt_q + CntOne;
            2'b01:   ram_cnt_d = ram_cnt_q - CntOne;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        if (push) tail_d = tail_q + 2'd1;
        if (pop)  head_d = head_q + 2'd1;

        unique case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 3'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 3'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase

        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            vpipe_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            buf_cnt_d = '0;
        end

        inflight_next = popcnt(vpipe_d);
        level_d = ram_cnt_d
                  + {{(ADDR_WIDTH-1){1'b0}}, inflight_next}
                  + {{(ADDR_WIDTH-2){1'b0}}, buf_cnt_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            vpipe_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            buf_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            vpipe_q   <= vpipe_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            buf_cnt_q <= buf_cnt_d;
            if (push && !flush) begin
                buf_q[tail_q] <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed + randomised bench for fifo_ram_ctrl with D=8, one instance per read latency.
// Each instance has its own behavioural RAM and an in-order scoreboard.
module tb_fifo_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       ir0, ov0, we0, re0, ir1, ov1, we1, re1;
    logic [7:0] od0, wd0, rd0, od1, wd1, rd1;
    logic [2:0] wa0, ra0, wa1, ra1;
    logic [3:0] lvl0, lvl1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    fifo_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .OUTPUT_REG("TRUE")) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .ram_we(we0), .ram_waddr(wa0), .ram_wdata(wd0),
        .ram_re(re0), .ram_raddr(ra0), .ram_rdata(rd0),
        .level(lvl0)
    );

    fifo_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .OUTPUT_REG("FALSE")) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .ram_we(we1), .ram_waddr(wa1), .ram_wdata(wd1),
        .ram_re(re1), .ram_raddr(ra1), .ram_rdata(rd1),
        .level(lvl1)
    );

    // RAM models: two-stage read for instance 0, single-stage for instance 1.
    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];
    logic [7:0] r1_0;
    always @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        if (re0) r1_0 <= mem0[ra0];
        rd0 <= r1_0;
        if (we1) mem1[wa1] <= wd1;
        if (re1) rd1 <= mem1[ra1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
        end else begin
            check("lvl0", 32'(lvl0), 32'(q0.size()));
            check("bnd0", 32'(lvl0 <= 4'd12), 32'd1);
            if (flush) begin
                q0.delete();
            end else begin
                if (ov0 && out_ready) begin
                    if (q0.size() == 0) check("spur0", 32'(ov0), 32'd0);
                    else check("ord0", 32'(od0), 32'(q0.pop_front()));
                end
                if (in_valid && ir0) q0.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
        end else begin
            check("lvl1", 32'(lvl1), 32'(q1.size()));
            if (flush) begin
                q1.delete();
            end else begin
                if (ov1 && out_ready) begin
                    if (q1.size() == 0) check("spur1", 32'(ov1), 32'd0);
                    else check("ord1", 32'(od1), 32'(q1.pop_front()));
                end
                if (in_valid && ir1) q1.push_back(in_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    logic       ov_h[10], ov1_h[10], re_h[10];
    logic [7:0] od_h[10];
    logic [3:0] lvl_h[10];
    int         n;
    logic       found;
    logic [7:0] d;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b0;
        #3;
        check("rst_ov", 32'(ov0), 32'd0);
        check("rst_ir", 32'(ir0), 32'd1);
        check("rst_lvl", 32'(lvl0), 32'd0);
        check("rst_re", 32'(re0), 32'd0);
        check("rst_we", 32'(we0), 32'd1);
        check("rst_od", 32'(od0), 32'd0);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Five words with consumer always ready: latency and back-to-back output.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 5);
            in_data  = 8'(k + 1);
            @(negedge clk);
            ov_h[k] = ov0; od_h[k] = od0; ov1_h[k] = ov1; re_h[k] = re0; lvl_h[k] = lvl0;
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("lat2_ov%0d", k), 32'(ov_h[k]), 32'(k >= 4 && k <= 8));
            if (k >= 4 && k <= 8) check($sformatf("lat2_od%0d", k), 32'(od_h[k]), 32'(k - 3));
            check($sformatf("lat1_ov%0d", k), 32'(ov1_h[k]), 32'(k >= 3 && k <= 7));
        end
        check("first_re", 32'(re_h[1]), 32'd1);
        check("lvl_k2", 32'(lvl_h[2]), 32'd2);
        check("lvl_k9", 32'(lvl_h[9]), 32'd0);

        // Fill to full with consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_ir", 32'(ir0), 32'd0);
        check("full_lvl", 32'(lvl0), 32'd12);
        check("full_ov", 32'(ov0), 32'd1);
        check("full_od", 32'(od0), 32'h10);
        check("full_re", 32'(re0), 32'd0);
        cyc();
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("B_re", 32'(re0), 32'd1);
        check("B_ir", 32'(ir0), 32'd0);
        cyc();
        // ram_cnt is D-1 here; write and read-issue coincide.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
        @(negedge clk);
        check("C_ir", 32'(ir0), 32'd1);
        check("C_re", 32'(re0), 32'd1);
        check("C_we", 32'(we0), 32'd1);
        cyc();
        in_data = 8'h41;
        @(negedge clk);
        check("D_ir", 32'(ir0), 32'd1);
        check("D_lvl", 32'(lvl0), 32'd11);
        check("D_re", 32'(re0), 32'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("E_ir", 32'(ir0), 32'd0);
        check("E_lvl", 32'(lvl0), 32'd12);
        cyc();
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov0) n++;
            cyc();
        end
        check("drain_cnt", 32'(n), 32'd12);
        check("drain_lvl", 32'(lvl0), 32'd0);

        // Flush with two reads in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; cyc();
        in_data = 8'h02; cyc();
        in_valid = 1'b0; cyc();
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        check("fl_lvl", 32'(lvl0), 32'd2);
        check("fl_we", 32'(we0), 32'd0);
        check("fl_re", 32'(re0), 32'd0);
        cyc();
        flush = 1'b0; in_data = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        check("post_fl_ov", 32'(ov0), 32'd0);
        check("post_fl_lvl", 32'(lvl0), 32'd0);
        cyc();
        in_valid = 1'b0;
        found = 1'b0; d = 8'h00;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ov0) begin found = 1'b1; d = od0; end
            cyc();
        end
        check("a5_seen", 32'(found), 32'd1);
        check("a5_data", 32'(d), 32'hA5);
        @(negedge clk);
        check("a5_alone", 32'(ov0), 32'd0);
        cyc();

        // Asynchronous reset between edges while streaming.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + i); cyc();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(ov0), 32'd0);
        check("arst_ir", 32'(ir0), 32'd1);
        check("arst_lvl", 32'(lvl0), 32'd0);
        check("arst_re", 32'(re0), 32'd0);
        check("arst_we", 32'(we0), 32'd1);
        check("arst_od", 32'(od0), 32'd0);
        #4;
        rst_n = 1'b1; in_valid = 1'b0;
        cyc();
        in_valid = 1'b1; in_data = 8'h3C;
        cyc();
        in_valid = 1'b0;
        found = 1'b0; d = 8'h00;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ov0) begin found = 1'b1; d = od0; end
            cyc();
        end
        check("rst_new_seen", 32'(found), 32'd1);
        check("rst_new_data", 32'(d), 32'h3C);

        // Random traffic; pointers wrap many times at D=8.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 100 && (lvl0 != 4'd0 || lvl1 != 4'd0); i++) cyc();
        @(negedge clk);
        check("rnd_lvl0", 32'(lvl0), 32'd0);
        check("rnd_lvl1", 32'(lvl1), 32'd0);
        check("rnd_q0", 32'(q0.size()), 32'd0);
        check("rnd_q1", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
